dma_reader: RTL

//  AXI3 read master for the PS HP0 read channel; the read-side counterpart of the HP0 write DMA.

---
 rtl/pdh_axi_pkg.sv | 15 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/dma_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pdh_axi_pkg.sv
// Shared AXI3 constants and the read-DMA state encoding for the HP0 masters.
package pdh_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } dma_rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head: a pushed word becomes visible the cycle after the push.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  property p_no_overflow;
    @(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i);
  endproperty
  assert property (p_no_overflow);

endmodule

// File: rtl/dma_reader.sv
// AXI3 read master: fetches num_bursts fixed INCR bursts from DDR into a FIFO and streams them out.
module dma_reader
  import pdh_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  aclk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [15:0]           num_bursts_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           m_axi_araddr,
  output logic [3:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int OFF_W  = $clog2(BURST_LEN * 8);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  LEN_C       = CNT_W'(BURST_LEN);

  dma_rd_state_t     state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [15:0]       num_q, num_d;
  logic [15:0]       idx_q, idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              space_ok, r_hs, last_beat, burst_end, pop;

  // Free space can only grow while in ADDR (no pushes there), so arvalid stays up once raised.
  assign space_ok  = !fifo_full && ((DEPTH_C - fifo_count) >= LEN_C);
  assign r_hs      = (state_q == DATA) && m_axi_rvalid;
  assign last_beat = (beat_q == LAST_BEAT);
  assign burst_end = r_hs && (m_axi_rlast || last_beat);
  assign pop       = valid_o && ready_i;

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DRAIN) && fifo_empty;
  assign err_o         = err_q;
  assign m_axi_araddr  = base_q + 32'(idx_q) * BURST_BYTES;
  assign m_axi_arlen   = 4'(BURST_LEN - 1);
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = (state_q == ADDR) && space_ok;
  assign m_axi_rready  = (state_q == DATA);
  assign valid_o       = !fifo_empty;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          num_d  = num_bursts_i;
          idx_d  = '0;
          beat_d = '0;
          err_d  = 1'b0;
          if (base_addr_i[OFF_W-1:0] != '0) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else if (num_bursts_i == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (m_axi_arvalid && m_axi_arready) state_d = DATA;
      end
      DATA: begin
        if (r_hs) begin
          if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat)) err_d = 1'b1;
          if (burst_end) begin
            beat_d  = '0;
            idx_d   = idx_q + 16'd1;
            state_d = (({1'b0, idx_q} + 17'd1) == {1'b0, num_q}) ? DRAIN : ADDR;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (rst_i),
    .push_i  (r_hs),
    .wdata_i (m_axi_rdata),
    .pop_i   (pop),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
